// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer and fetch controller for the
//                9-bit-instruction core. Runs fetch from a start request to a
//                halt, resolves branches through a 4-entry signed offset LUT
//                indexed by how_high, inserts a one-cycle bubble after loads
//                and drives the start/done handshake.
//                Optional macro PC_SEQ_CYCLE_COUNT_EN enables a saturating
//                16-bit count of RUN/WAIT cycles on cycle_count; without it
//                cycle_count is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_WIDTH   = 10,
    parameter int START_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                branch,
    input  logic [1:0]          how_high,
    input  logic                mem_read,
    input  logic                halt,
    input  logic                lut_wr_en,
    input  logic [1:0]          lut_wr_addr,
    input  logic [PC_WIDTH-1:0] lut_wr_data,
    output logic [PC_WIDTH-1:0] prog_ctr,
    output logic                fetch_valid,
    output logic                done,
    output logic [15:0]         cycle_count
);

    localparam logic [PC_WIDTH-1:0] c_start_pc = PC_WIDTH'(START_ADDR);
    localparam logic [PC_WIDTH-1:0] c_pc_one   = PC_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                done_q, done_d;
    logic [PC_WIDTH-1:0] lut_q [4];
    logic [PC_WIDTH-1:0] lut_d [4];
    logic                start_accept;

    // Offsets are stored at full PC width, so the sign extension is implicit
    // and a plain modulo-2^PC_WIDTH add realises both forward and backward
    // branches, including wrap below zero.

    // Next-state, next-PC and done decode
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    pc_d         = c_start_pc;
                    start_accept = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DONE;
                end else if (branch) begin
                    pc_d = pc_q + lut_q[how_high];
                end else if (mem_read) begin
                    state_d = ST_WAIT;
                end else begin
                    pc_d = pc_q + c_pc_one;
                end
            end
            ST_WAIT: begin
                state_d = ST_RUN;
                pc_d    = pc_q + c_pc_one;
            end
            ST_DONE: begin
                // start is only honoured once sampled while already in DONE
                if (start) begin
                    state_d      = ST_RUN;
                    pc_d         = c_start_pc;
                    start_accept = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    // LUT write path; a same-cycle branch reads lut_q, i.e. the old value
    always_comb begin
        lut_d = lut_q;
        if (lut_wr_en) begin
            lut_d[lut_wr_addr] = lut_wr_data;
        end
    end

    // Sequencer and LUT state registers; reset overrides any write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            lut_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            lut_q   <= lut_d;
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of executed (RUN/WAIT) cycles, cleared on each start
    always_comb begin
        cnt_d = cnt_q;
        if (start_accept) begin
            cnt_d = '0;
        end else if (((state_q == ST_RUN) || (state_q == ST_WAIT)) &&
                     (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign cycle_count         = 16'd0;
`endif

    assign prog_ctr    = pc_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign done        = done_q;

endmodule
`default_nettype wire
